// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a load/store port onto one memory port,
// with data priority bounded by a fairness limit and a per-transaction timeout.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 255,
   parameter int FAIR_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_ready,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_ready,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy,
   output logic                err
);
   localparam int FC_W = $clog2(FAIR_LIMIT + 1);
   localparam int WC_W = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;
   state_t state, state_nxt;
   logic [FC_W-1:0] fcnt;
   logic [WC_W-1:0] wcnt;
   logic grant_d, grant_f, done, tmo, fair_hit;
   assign mem_req  = state != IDLE;
   assign busy     = state != IDLE;
   assign fair_hit = fcnt == FC_W'(FAIR_LIMIT);
   always_comb begin
      state_nxt = state;
      grant_d   = 1'b0;
      grant_f   = 1'b0;
      done      = 1'b0;
      tmo       = 1'b0;
      if (state == IDLE) begin
         // no grant while a ready pulse is out: the requester gets that cycle to drop req
         if (!(if_ready || d_ready)) begin
            grant_d = d_req && !(fair_hit && if_req);
            grant_f = if_req && !grant_d;
         end
         state_nxt = grant_d ? DATA : grant_f ? FETCH : IDLE;
      end else begin
         done      = mem_ready;
         tmo       = !mem_ready && wcnt == WC_W'(TIMEOUT - 1);
         state_nxt = (done || tmo) ? IDLE : state;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         fcnt      <= '0;
         wcnt      <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         if_ready  <= 1'b0;
         d_ready   <= 1'b0;
         err       <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         state    <= state_nxt;
         if_ready <= (done || tmo) && state == FETCH;
         d_ready  <= (done || tmo) && state == DATA;
         err      <= tmo;
         if (done && state == FETCH) if_rdata <= mem_rdata;
         if (done && state == DATA && !mem_we) d_rdata <= mem_rdata;
         if (grant_d) begin
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            wcnt      <= '0;
            if (if_req && !fair_hit) fcnt <= fcnt + 1'b1;
         end else if (grant_f) begin
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_be    <= '1;
            wcnt      <= '0;
            fcnt      <= '0;
         end else if (state != IDLE && !mem_ready) begin
            wcnt <= wcnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with TIMEOUT=8, FAIR_LIMIT=4.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
   logic [3:0]  d_be = '0;
   logic        if_ready, d_ready, mem_req, mem_we, busy, err;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   int          vectors = 0, miscompares = 0;
   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .FAIR_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy), .err(err)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask
   task automatic wait_grant(input string tag);
      int n = 0;
      while (!mem_req && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_grant"}, 64'(mem_req), 64'd1);
   endtask
   task automatic serve(input int lat, input logic [31:0] rd);
      repeat (lat - 1) tick();
      mem_ready = 1'b1;
      mem_rdata = rd;
      tick();
      mem_ready = 1'b0;
   endtask
   initial begin
      int cnt;
      tick();
      tick();
      check("rst_mem_req", 64'(mem_req), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_outs", {if_ready, d_ready, err, mem_we, mem_be}, 0);
      check("rst_regs", {if_rdata, d_rdata}, 0);
      check("rst_addr", {mem_addr, mem_wdata}, 0);
      rst = 1'b0;
      // fetch, minimum latency
      if_req = 1'b1; if_addr = 32'h100;
      tick();
      check("f_mem_req", 64'(mem_req), 1);
      check("f_addr", 64'(mem_addr), 64'h100);
      check("f_we_be", {mem_we, mem_be}, 64'h0F);
      check("f_busy", 64'(busy), 1);
      serve(1, 32'h00500093);
      check("f_ready", 64'(if_ready), 1);
      check("f_rdata", 64'(if_rdata), 64'h00500093);
      check("f_idle", {mem_req, busy, d_ready, err}, 0);
      if_req = 1'b0;
      tick();
      check("f_pulse_once", 64'(if_ready), 0);
      // simultaneous: data wins, fetch follows
      if_req = 1'b1; if_addr = 32'h104;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
      tick();
      check("s_addr_data", 64'(mem_addr), 64'h2000);
      check("s_we", 64'(mem_we), 0);
      serve(1, 32'h11112222);
      check("s_d_ready", {d_ready, if_ready}, 64'b10);
      check("s_d_rdata", 64'(d_rdata), 64'h11112222);
      d_req = 1'b0;
      tick();
      check("s_gap", 64'(mem_req), 0);
      tick();
      check("s_fetch_req", 64'(mem_req), 1);
      check("s_fetch_addr", 64'(mem_addr), 64'h104);
      serve(2, 32'h33334444);
      check("s_if_ready", {if_ready, d_ready}, 64'b10);
      check("s_if_rdata", 64'(if_rdata), 64'h33334444);
      if_req = 1'b0;
      // store, fields changed after grant must be ignored
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
      wait_grant("st");
      d_addr = 32'h9999; d_wdata = 32'h0; d_be = 4'hF;
      tick();
      check("st_addr", 64'(mem_addr), 64'h2004);
      check("st_we_be", {mem_we, mem_be}, 64'h13);
      check("st_wdata", 64'(mem_wdata), 64'hDEADBEEF);
      serve(2, 32'h55555555);
      check("st_ready", 64'(d_ready), 1);
      check("st_rdata_kept", 64'(d_rdata), 64'h11112222);
      // starvation: 5th grant goes to fetch, then data again
      d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF;
      if_req = 1'b1; if_addr = 32'h200;
      for (int i = 1; i <= 6; i++) begin
         wait_grant($sformatf("fair%0d", i));
         check($sformatf("fair%0d_addr", i), 64'(mem_addr), (i == 5) ? 64'h200 : 64'h3000);
         serve(1, 32'h1000 + 32'(i));
      end
      check("fair_d_rdata", 64'(d_rdata), 64'h1006);
      check("fair_if_rdata", 64'(if_rdata), 64'h1005);
      // timeout
      if_req = 1'b0; d_addr = 32'h4000;
      wait_grant("to");
      cnt = 0;
      while (mem_req && cnt < 20) begin
         cnt++;
         tick();
      end
      check("to_cycles", 64'(cnt), 8);
      check("to_err_ready", {err, d_ready}, 64'b11);
      check("to_rdata_kept", 64'(d_rdata), 64'h1006);
      check("to_idle", {busy, mem_req}, 0);
      // mem_ready on the timeout cycle completes normally
      d_addr = 32'h4004;
      wait_grant("tp");
      check("tp_err_clear", 64'(err), 0);
      repeat (7) tick();
      check("tp_still_req", 64'(mem_req), 1);
      serve(1, 32'hABCD0123);
      check("tp_ready_noerr", {d_ready, err}, 64'b10);
      check("tp_rdata", 64'(d_rdata), 64'hABCD0123);
      d_req = 1'b0;
      // reset in the middle of a fetch
      if_req = 1'b1; if_addr = 32'h300;
      wait_grant("rm");
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; if_req = 1'b0;
      mem_ready = 1'b1; mem_rdata = 32'h77;
      check("rm_abort", {mem_req, busy, if_ready, err}, 0);
      tick();
      mem_ready = 1'b0;
      check("rm_late_ready", {mem_req, busy, if_ready, err}, 0);
      check("rm_rdata", 64'(if_rdata), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
